car_request_conditioner: RTL and testbench

//  Upstream conditioning stage for countdown_controller's `car` input.
//  - Synchronises and debounces the raw, asynchronous country-road vehicle sensor.
//  - Latches a service request so a car that leaves early is still served once.
//  - Flags a sensor stuck high, and keeps a saturating count of arrivals.
//  - `car` drives countdown_controller.car; country_gry is fed back from it.

---
 rtl/traffic_pkg.sv | 7 +
 rtl/sync_debounce.sv | 32 +++
 rtl/car_request_conditioner.sv | 58 +++++
 tb/tb_car_request_conditioner.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: light indices and clock default shared by the traffic controller blocks
package traffic_pkg;
  localparam int G_IDX = 2;
  localparam int R_IDX = 1;
  localparam int Y_IDX = 0;
  localparam int CLK_FREQ = 50_000_000;
endpackage

// File: rtl/sync_debounce.sv
// sync_debounce: two-flop synchroniser plus debounce counter for a raw asynchronous input
// clk, rst    : clock, asynchronous active-high reset
// raw         : asynchronous input, may bounce
// stable      : debounced level, changes only after DEBOUNCE_CYCLES steady post-sync cycles
module sync_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);
  logic s1, s2;
  logic [DW-1:0] db_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      stable <= 1'b0;
      db_cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == stable) db_cnt <= '0;
      else if (db_cnt == DB_MAX) begin
        stable <= s2;
        db_cnt <= '0;
      end else db_cnt <= db_cnt + 1'b1;
    end
endmodule

// File: rtl/car_request_conditioner.sv
// car_request_conditioner: conditions the country-road vehicle sensor into the controller car request
// clk, rst      : clock, asynchronous active-high reset
// car_raw       : raw asynchronous sensor
// country_gry   : country light fed back from the controller, green clears a pending request
// car           : registered request to the controller
// car_stable    : debounced sensor level
// arrival_pulse : one-cycle pulse after each debounced rising edge
// sensor_fault  : debounced level stuck high for STUCK_CYCLES
// arrival_count : saturating arrival count
module car_request_conditioner
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STUCK_CYCLES = 500000,
  parameter int CNT_BITS = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic car_raw,
  input  logic [2:0] country_gry,
  output logic car,
  output logic car_stable,
  output logic arrival_pulse,
  output logic sensor_fault,
  output logic [CNT_BITS-1:0] arrival_count
);
  localparam int SW = $clog2(STUCK_CYCLES + 1);
  localparam logic [SW-1:0] STUCK_MAX = SW'(STUCK_CYCLES);
  logic stable_d, pending;
  logic [SW-1:0] stuck_cnt;
  sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
    .clk(clk),
    .rst(rst),
    .raw(car_raw),
    .stable(car_stable)
  );
  assign sensor_fault = stuck_cnt == STUCK_MAX;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stable_d <= 1'b0;
      arrival_pulse <= 1'b0;
      pending <= 1'b0;
      car <= 1'b0;
      stuck_cnt <= '0;
      arrival_count <= '0;
    end else begin
      stable_d <= car_stable;
      arrival_pulse <= car_stable & ~stable_d;
      // green means the waiting car is being served, so clear beats a coincident arrival
      if (country_gry[G_IDX]) pending <= 1'b0;
      else if (arrival_pulse) pending <= 1'b1;
      // a stuck sensor must not hold the request forever; only a latched arrival gets through
      car <= pending | (car_stable & ~sensor_fault);
      if (!car_stable) stuck_cnt <= '0;
      else if (stuck_cnt != STUCK_MAX) stuck_cnt <= stuck_cnt + 1'b1;
      if (arrival_pulse && arrival_count != '1) arrival_count <= arrival_count + 1'b1;
    end
endmodule

// File: tb/tb_car_request_conditioner.sv
// tb_car_request_conditioner: scoreboard bench for car_request_conditioner
module tb_car_request_conditioner;
  localparam int DB = 4;
  localparam int ST = 50;
  localparam int CB = 3;
  localparam int CMAX = (1 << CB) - 1;
  typedef struct {
    int cyc;
    int cnt;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic car_raw = 1'b0;
  logic [2:0] country_gry = 3'b010;
  logic car, car_stable, arrival_pulse, sensor_fault;
  logic [CB-1:0] arrival_count;
  int cyc = 0;
  int checks = 0, passed = 0, mchecks = 0, mpassed = 0, exp_cnt = 0;
  exp_t q[$];
  exp_t e;
  logic cnt_due = 1'b0;
  int cnt_want = 0;

  car_request_conditioner #(.DEBOUNCE_CYCLES(DB), .STUCK_CYCLES(ST), .CNT_BITS(CB)) dut (
    .clk(clk),
    .rst(rst),
    .car_raw(car_raw),
    .country_gry(country_gry),
    .car(car),
    .car_stable(car_stable),
    .arrival_pulse(arrival_pulse),
    .sensor_fault(sensor_fault),
    .arrival_count(arrival_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cnt_due && !rst) begin
      mchecks++;
      if (arrival_count !== CB'(cnt_want))
        $display("FAIL pulse_count: arrival_count %0d, expected %0d", arrival_count, cnt_want);
      else mpassed++;
    end
    cnt_due = 1'b0;
    if (!rst && arrival_pulse) begin
      mchecks++;
      if (q.size() == 0) $display("FAIL pulse_unexpected: pulse at cycle %0d, none expected", cyc);
      else begin
        e = q.pop_front();
        if (cyc !== e.cyc) $display("FAIL pulse_time: pulse at cycle %0d, expected %0d", cyc, e.cyc);
        else mpassed++;
        cnt_due = 1'b1;
        cnt_want = e.cnt;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_arrival();
    exp_cnt = exp_cnt < CMAX ? exp_cnt + 1 : CMAX;
    q.push_back('{cyc + 7, exp_cnt});
  endtask

  task automatic test_reset();
    tick(2);
    checks++;
    if ({car, car_stable, arrival_pulse, sensor_fault, arrival_count} !== '0)
      $display("FAIL reset_hold: outputs %b, expected 0", {car, car_stable, arrival_pulse, sensor_fault, arrival_count});
    else passed++;
    rst = 1'b0;
    tick(3);
    checks++;
    if ({car, car_stable, arrival_pulse, sensor_fault, arrival_count} !== '0)
      $display("FAIL reset_release: outputs %b, expected 0", {car, car_stable, arrival_pulse, sensor_fault, arrival_count});
    else passed++;
  endtask

  task automatic test_arrival();
    country_gry = 3'b010;
    push_arrival();
    car_raw = 1'b1;
    tick(5);
    checks++;
    if (car_stable !== 1'b0) $display("FAIL arr_early: car_stable %b after 5 edges, expected 0", car_stable);
    else passed++;
    tick(1);
    checks++;
    if ({car_stable, arrival_pulse} !== 2'b10) $display("FAIL arr_stable: stable,pulse %b, expected 10", {car_stable, arrival_pulse});
    else passed++;
    tick(1);
    checks++;
    if ({arrival_pulse, car} !== 2'b11) $display("FAIL arr_pulse: pulse,car %b, expected 11", {arrival_pulse, car});
    else passed++;
    tick(1);
    checks++;
    if ({arrival_pulse, car} !== 2'b01 || arrival_count !== CB'(exp_cnt))
      $display("FAIL arr_after: pulse,car %b count %0d, expected 01 count %0d", {arrival_pulse, car}, arrival_count, exp_cnt);
    else passed++;
    car_raw = 1'b0;
    tick(8);
    country_gry = 3'b100;
    tick(2);
    country_gry = 3'b010;
    tick(1);
    checks++;
    if (car !== 1'b0) $display("FAIL arr_served: car %b, expected 0", car);
    else passed++;
  endtask

  task automatic test_pending();
    country_gry = 3'b010;
    push_arrival();
    car_raw = 1'b1;
    tick(6);
    car_raw = 1'b0;
    tick(8);
    checks++;
    if ({car_stable, car} !== 2'b01) $display("FAIL pend_latched: stable,car %b, expected 01", {car_stable, car});
    else passed++;
    tick(4);
    checks++;
    if (car !== 1'b1) $display("FAIL pend_red_hold: car %b, expected 1", car);
    else passed++;
    country_gry = 3'b100;
    tick(1);
    checks++;
    if (car !== 1'b1) $display("FAIL pend_clear_edge: car %b, expected 1", car);
    else passed++;
    tick(1);
    checks++;
    if (car !== 1'b0) $display("FAIL pend_cleared: car %b, expected 0", car);
    else passed++;
    country_gry = 3'b010;
    tick(2);
    checks++;
    if (car !== 1'b0) $display("FAIL pend_stay_clear: car %b, expected 0", car);
    else passed++;
  endtask

  task automatic test_bounce();
    country_gry = 3'b010;
    car_raw = 1'b1;
    tick(3);
    car_raw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      checks++;
      if ({car_stable, arrival_pulse, car} !== 3'b000)
        $display("FAIL bounce_cycle%0d: stable,pulse,car %b, expected 000", i, {car_stable, arrival_pulse, car});
      else passed++;
    end
    checks++;
    if (arrival_count !== CB'(exp_cnt)) $display("FAIL bounce_count: count %0d, expected %0d", arrival_count, exp_cnt);
    else passed++;
  endtask

  task automatic test_stuck();
    int start, n;
    country_gry = 3'b010;
    start = cyc;
    push_arrival();
    car_raw = 1'b1;
    tick(9);
    country_gry = 3'b100;
    tick(1);
    country_gry = 3'b010;
    n = 0;
    while (!sensor_fault && n < 80) begin
      tick(1);
      n++;
    end
    checks++;
    if (sensor_fault !== 1'b1 || cyc != start + 6 + ST)
      $display("FAIL stuck_rise: fault %b at cycle %0d, expected 1 at %0d", sensor_fault, cyc, start + 6 + ST);
    else passed++;
    tick(1);
    checks++;
    if ({car_stable, car} !== 2'b10) $display("FAIL stuck_car_drop: stable,car %b, expected 10", {car_stable, car});
    else passed++;
    tick(start + 60 - cyc);
    car_raw = 1'b0;
    tick(6);
    checks++;
    if ({sensor_fault, car_stable} !== 2'b10) $display("FAIL stuck_fall_edge: fault,stable %b, expected 10", {sensor_fault, car_stable});
    else passed++;
    tick(1);
    checks++;
    if (sensor_fault !== 1'b0) $display("FAIL stuck_clear: fault %b, expected 0", sensor_fault);
    else passed++;
    tick(2);
  endtask

  task automatic test_reset_mid();
    country_gry = 3'b010;
    push_arrival();
    car_raw = 1'b1;
    tick(9);
    checks++;
    if ({car, car_stable} !== 2'b11) $display("FAIL rstmid_pre: car,stable %b, expected 11", {car, car_stable});
    else passed++;
    rst = 1'b1;
    #1;
    checks++;
    if ({car, car_stable, arrival_pulse, sensor_fault, arrival_count} !== '0)
      $display("FAIL rstmid_async: outputs %b, expected 0", {car, car_stable, arrival_pulse, sensor_fault, arrival_count});
    else passed++;
    car_raw = 1'b0;
    exp_cnt = 0;
    tick(2);
    rst = 1'b0;
    tick(10);
    checks++;
    if ({car, car_stable, arrival_count} !== '0)
      $display("FAIL rstmid_after: car,stable,count %b, expected 0", {car, car_stable, arrival_count});
    else passed++;
  endtask

  task automatic test_saturate();
    country_gry = 3'b010;
    for (int i = 0; i < 9; i++) begin
      push_arrival();
      car_raw = 1'b1;
      tick(8);
      car_raw = 1'b0;
      tick(8);
      checks++;
      if (arrival_count !== CB'(exp_cnt)) $display("FAIL sat_count%0d: count %0d, expected %0d", i, arrival_count, exp_cnt);
      else passed++;
    end
    country_gry = 3'b100;
    tick(1);
    country_gry = 3'b010;
    tick(1);
    push_arrival();
    car_raw = 1'b1;
    tick(7);
    country_gry = 3'b100;
    tick(1);
    country_gry = 3'b010;
    car_raw = 1'b0;
    tick(8);
    checks++;
    if ({car, car_stable} !== 2'b00) $display("FAIL green_coincide: car,stable %b, expected 00", {car, car_stable});
    else passed++;
    checks++;
    if (arrival_count !== CB'(CMAX)) $display("FAIL sat_final: count %0d, expected %0d", arrival_count, CMAX);
    else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_arrival();
    test_pending();
    test_bounce();
    test_stuck();
    test_reset_mid();
    test_saturate();
    tick(2);
    checks++;
    if (q.size() != 0) $display("FAIL missing_pulses: %0d expected pulses not seen, expected 0", q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed + mpassed, checks + mchecks);
    $finish;
  end
endmodule
